// File: rtl/match_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// game-core finish codes and round limits.
// Combinational only; no flow control.
package match_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PREP       = 3'd1,
        FIGHT      = 3'd2,
        ROUND_END  = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    // Finish codes from the game core; match_winner reuses the same encoding.
    localparam logic [1:0] FIN_NONE = 2'b00;
    localparam logic [1:0] FIN_P1   = 2'b01;
    localparam logic [1:0] FIN_P2   = 2'b11;

    localparam logic [3:0] ROUND_MAX = 4'd15;

    // The unused code 10 carries no result and is folded onto "still running".
    function automatic logic [1:0] norm_finish(input logic [1:0] raw);
        return (raw == 2'b10) ? FIN_NONE : raw;
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Bundle between the match controller and its surroundings (button, game core, HUD).
// Pure wiring, no latency.
// No backpressure: all signals are levels sampled every cycle.
interface match_ctrl_if;
    import match_pkg::*;

    logic       start_btn;
    logic [1:0] finish;
    logic [3:0] p1_health;
    logic [3:0] p2_health;
    logic       game_reset_n;
    logic [2:0] state;
    logic [3:0] round_num;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] match_winner;
    logic [6:0] time_left;

    // Drives the controller: button and game core side.
    modport master (
        output start_btn, finish, p1_health, p2_health,
        input  game_reset_n, state, round_num, p1_rounds, p2_rounds,
               match_winner, time_left
    );

    // The match controller itself.
    modport slave (
        input  start_btn, finish, p1_health, p2_health,
        output game_reset_n, state, round_num, p1_rounds, p2_rounds,
               match_winner, time_left
    );

endinterface

// File: rtl/match_ctrl_sec_tick.sv
// One-second tick generator: prescaler over CLK_HZ clock cycles.
// Pulse is high for one cycle every CLK_HZ cycles, the last cycle of each period.
// No backpressure; clr restarts the period so the first pulse lands CLK_HZ cycles later.
module sec_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // Prescaler: wraps at CLK_HZ-1, restarts on reset or clear.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer for a two-player fighting game: start, prep, fight, round end, match over.
// All outputs registered; state changes one cycle after the triggering input or 1 s tick.
// No backpressure. Optional round timer with health tiebreak under macro ROUND_TIMER_EN.
module match_ctrl
    import match_pkg::*;
#(
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int CLK_HZ         = 100_000_000,
    parameter int INTERMISSION_S = 3,
    parameter int ROUND_TIME_S   = 60
) (
    input  logic         clk,
    input  logic         reset,
    match_ctrl_if.slave  bus
);

    localparam int SEC_W = (INTERMISSION_S > 1) ? $clog2(INTERMISSION_S) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(INTERMISSION_S - 1);
    localparam logic [1:0]       WIN_TARGET = 2'(ROUNDS_TO_WIN);

    state_t           state_q;
    logic             start_prev;
    logic [3:0]       round_q;
    logic [1:0]       p1_q;
    logic [1:0]       p2_q;
    logic [1:0]       winner_q;
    logic             game_rst_q;
    logic             draw_q;
    logic [SEC_W-1:0] sec_cnt;

    logic             tick;
    logic             start_rise;
    logic             inter_done;
    logic [1:0]       fin;
    logic             round_over;
    logic             p1_win;
    logic             p2_win;
    logic             leave;

    assign start_rise = bus.start_btn & ~start_prev;
    assign inter_done = tick && (sec_cnt == SEC_LAST);
    assign fin        = norm_finish(bus.finish);

`ifdef ROUND_TIMER_EN
    logic [6:0] time_q;
    logic       timeout;

    // The tick that takes the clock from 1 to 0 ends the round.
    assign timeout    = (state_q == FIGHT) && tick && (time_q == 7'd1);
    assign round_over = (fin != FIN_NONE) || timeout;

    // Round clock: loaded when the fight starts, counts down on each tick, holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            time_q <= '0;
        end else if (state_q == PREP && inter_done) begin
            time_q <= 7'(ROUND_TIME_S);
        end else if (state_q == FIGHT && tick && time_q != 7'd0) begin
            time_q <= time_q - 7'd1;
        end
    end

    assign bus.time_left = time_q;
`else
    assign round_over    = (fin != FIN_NONE);
    assign bus.time_left = 7'd0;
`endif

    // Round result: an explicit finish wins over a simultaneous timeout; equal health is a draw.
    always_comb begin
        p1_win = (fin == FIN_P1);
        p2_win = (fin == FIN_P2);
`ifdef ROUND_TIMER_EN
        if (fin == FIN_NONE && timeout) begin
            p1_win = (bus.p1_health > bus.p2_health);
            p2_win = (bus.p2_health > bus.p1_health);
        end
`endif
    end

    // Exit condition of the current state; also restarts the tick and second counters.
    always_comb begin
        leave = 1'b0;
        case (state_q)
            IDLE, MATCH_OVER: leave = start_rise;
            PREP, ROUND_END:  leave = inter_done;
            FIGHT:            leave = round_over;
            default:          leave = 1'b1;
        endcase
    end

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (leave),
        .tick  (tick)
    );

    // Whole seconds spent in the intermission states, cleared on every state entry.
    always_ff @(posedge clk) begin
        if (!reset || leave) begin
            sec_cnt <= '0;
        end else if (tick && (state_q == PREP || state_q == ROUND_END)) begin
            sec_cnt <= sec_cnt + SEC_W'(1);
        end
    end

    // Match FSM with registered score, round and game-core reset outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            start_prev <= 1'b1;
            round_q    <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            winner_q   <= FIN_NONE;
            game_rst_q <= 1'b0;
            draw_q     <= 1'b0;
        end else begin
            start_prev <= bus.start_btn;
            case (state_q)
                IDLE, MATCH_OVER: begin
                    if (start_rise) begin
                        state_q    <= PREP;
                        round_q    <= 4'd1;
                        p1_q       <= '0;
                        p2_q       <= '0;
                        winner_q   <= FIN_NONE;
                        draw_q     <= 1'b0;
                        game_rst_q <= 1'b0;
                    end
                end
                PREP: begin
                    if (inter_done) begin
                        state_q    <= FIGHT;
                        game_rst_q <= 1'b1;
                    end
                end
                FIGHT: begin
                    // Leaving FIGHT here guarantees a single score update per round.
                    if (round_over) begin
                        state_q <= ROUND_END;
                        draw_q  <= !p1_win && !p2_win;
                        if (p1_win) p1_q <= p1_q + 2'd1;
                        if (p2_win) p2_q <= p2_q + 2'd1;
                    end
                end
                ROUND_END: begin
                    if (inter_done) begin
                        if (p1_q == WIN_TARGET) begin
                            state_q  <= MATCH_OVER;
                            winner_q <= FIN_P1;
                        end else if (p2_q == WIN_TARGET) begin
                            state_q  <= MATCH_OVER;
                            winner_q <= FIN_P2;
                        end else begin
                            // Game core is held in reset again while the next round is prepared.
                            state_q    <= PREP;
                            game_rst_q <= 1'b0;
                            if (!draw_q && round_q != ROUND_MAX) begin
                                round_q <= round_q + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    game_rst_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.game_reset_n = game_rst_q;
    assign bus.round_num    = round_q;
    assign bus.p1_rounds    = p1_q;
    assign bus.p2_rounds    = p2_q;
    assign bus.match_winner = winner_q;

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS_TO_WIN, default 2, meaning rounds needed to win the match (legal range 1..3).
REQ-002 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning clk cycles per 1 s tick.
REQ-003 The block SHALL have parameter INTERMISSION_S, default 3, meaning seconds spent in PREP and in ROUND_END (legal range ≥1).
REQ-004 The block SHALL have parameter ROUND_TIME_S, default 60, meaning round time limit in seconds (range 1..99).
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port start_btn, input, 1 bit: debounced start level.
REQ-008 The block SHALL have port finish, input, 2 bits: game core result (00 running, 01 P1 won, 11 P2 won; 10 ignored).
REQ-009 The block SHALL have ports p1_health and p2_health, input, 4 bits each: game core health.
REQ-010 The block SHALL have port game_reset_n, output, 1 bit: registered active-low reset driven to the game core.
REQ-011 The block SHALL have port state, output, 3 bits: current FSM state.
REQ-012 The block SHALL have port round_num, output, 4 bits: current round, 1-based, saturating at 15.
REQ-013 The block SHALL have ports p1_rounds and p2_rounds, output, 2 bits each: rounds won.
REQ-014 The block SHALL have port match_winner, output, 2 bits: 00 none, 01 P1, 11 P2.
REQ-015 The block SHALL have port time_left, output, 7 bits: seconds remaining in the round.

Function
REQ-016 The FSM SHALL have states IDLE, PREP, FIGHT, ROUND_END, MATCH_OVER.
REQ-017 start_btn SHALL be edge-detected; the previous-sample register SHALL reset to 1, so a button held through reset SHALL NOT trigger.
REQ-018 In IDLE or MATCH_OVER, a start rising edge SHALL enter PREP next cycle and SHALL clear the scores and match_winner. round_num SHALL become 1.
REQ-019 game_reset_n SHALL be 0 in IDLE and PREP, and 1 in FIGHT, ROUND_END and MATCH_OVER, so the game core stays frozen on its result after a round.
REQ-020 PREP SHALL last exactly INTERMISSION_S ticks, counted from the first tick after entry, then go to FIGHT.
REQ-021 In FIGHT, finish=01 SHALL increment p1_rounds and finish=11 SHALL increment p2_rounds. Either case SHALL enter ROUND_END on the next cycle, and the score SHALL update once per round.
REQ-022 ROUND_END SHALL last INTERMISSION_S ticks. Then:
  - if a score equals ROUNDS_TO_WIN, the block SHALL go to MATCH_OVER with match_winner set;
  - otherwise the block SHALL increment round_num and go to PREP.
REQ-023 All state changes SHALL occur in the same cycle as the 1 s tick that completes the count. The tick counter SHALL restart on every state entry.
REQ-024 finish=10 SHALL be treated as 00.

Reset
REQ-025 While reset=0, the block SHALL hold: state=IDLE, game_reset_n=0, round_num=0, p1_rounds=0, p2_rounds=0, match_winner=00, time_left=0, tick prescaler=0, second counter=0.
REQ-026 Reset asserted in any state SHALL take effect on the next clk edge with no residual score.

Configuration
REQ-027 With macro ROUND_TIMER_EN defined:
  - time_left SHALL load ROUND_TIME_S on PREP→FIGHT and decrement once per tick in FIGHT;
  - on reaching 0 with finish=00, the higher health SHALL win the round;
  - equal health SHALL be a draw: no score change, round_num unchanged, go via ROUND_END to PREP;
  - if finish≠00 and the timeout occur in the same cycle, finish SHALL take priority.
REQ-028 Without ROUND_TIMER_EN, time_left SHALL be constant 0 and rounds SHALL end only via finish.

Structure
REQ-029 State encodings and finish codes (FIN_NONE=00, FIN_P1=01, FIN_P2=11) SHALL live in the shared package match_pkg.
REQ-030 The 1 s tick SHALL be generated in sub-module sec_tick_gen. It SHALL take parameter CLK_HZ and a synchronous clear, and produce a 1-cycle pulse.

Verification (CLK_HZ=10, INTERMISSION_S=2, ROUND_TIME_S=5)
REQ-031 Reset held with start_btn=1, then released with start held → state stays IDLE and game_reset_n=0.
REQ-032 Start pulse → PREP for 20 cycles → FIGHT with game_reset_n=1 and round_num=1.
REQ-033 finish=01 for rounds 1 and 2 → p1_rounds=2, then MATCH_OVER with match_winner=01 after 20 cycles of ROUND_END.
REQ-034 With ROUND_TIMER_EN, finish held 00 and p1_health=9, p2_health=4 → time_left goes 5..0, then p1_rounds=1.
REQ-035 With ROUND_TIMER_EN, equal health at timeout → scores unchanged and round_num stays 1 after ROUND_END.
REQ-036 Reset pulsed mid-FIGHT with p2_rounds=1 → all outputs return to their REQ-025 values on the next edge.
